// File: rtl/adc_trigger_edge_multi.sv
// Multi-lane hysteresis edge trigger: chains a Schmitt comparator across LANES samples per word,
// qualifies edges by polarity, counts N events, then fires and applies a holdoff before re-arming.
module adc_trigger_edge_multi #(
   parameter int LANES     = 8,
   parameter int SAMPLE_W  = 8,
   parameter int HOLDOFF_W = 16,
   parameter int EVCNT_W   = 8
) (
   input  logic                        adc_data_clk,
   input  logic                        adc_rst_n,
   input  logic [LANES*SAMPLE_W-1:0]   adc_bus,
   input  logic                        adc_valid,
   input  logic [SAMPLE_W-1:0]         lvl_hi,
   input  logic [SAMPLE_W-1:0]         lvl_lo,
   input  logic [1:0]                  edge_mode,
   input  logic [EVCNT_W-1:0]          ev_count,
   input  logic [HOLDOFF_W-1:0]        holdoff,
   input  logic                        auto_rearm,
   input  logic                        arm,
   input  logic                        disarm,
   input  logic                        force_trig,
   output logic                        trigger_out,
   output logic [$clog2(LANES)-1:0]    trigger_sub_word,
   output logic [1:0]                  trig_state,
   output logic [EVCNT_W-1:0]          ev_counter
);

   localparam int LW = $clog2(LANES);
   localparam logic [HOLDOFF_W-1:0] HOLD_ONE = {{(HOLDOFF_W-1){1'b0}}, 1'b1};
   localparam logic [EVCNT_W:0]     EV_ONE   = {{EVCNT_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      ARMED   = 2'b01,
      HOLDOFF = 2'b10
   } state_t;

   state_t                state_r;
   logic                  s_r;
   logic [HOLDOFF_W-1:0]  hold_cnt_r;
   logic                  arm_q_r;
   logic                  force_q_r;
   logic                  trig_r;
   logic [LW-1:0]         sub_r;
   logic [EVCNT_W-1:0]    ev_r;

   logic                  thr_ok_s;
   logic                  s_next_s;
   logic                  rise_s;
   logic                  fall_s;
   logic                  qual_s;
   logic                  event_s;
   logic [LW-1:0]         event_lane_s;
   logic                  qualify_s;
   logic                  arm_rise_s;
   logic                  force_rise_s;
   logic [EVCNT_W:0]      ev_next_s;
   logic [EVCNT_W:0]      ev_need_s;
   logic                  ev_done_s;

   // Hysteresis chain across lanes, oldest first; keeps the first polarity-qualified event.
   always_comb begin
      thr_ok_s     = (lvl_lo < lvl_hi);
      s_next_s     = s_r;
      rise_s       = 1'b0;
      fall_s       = 1'b0;
      qual_s       = 1'b0;
      event_s      = 1'b0;
      event_lane_s = {LW{1'b0}};
      for (int i = 0; i < LANES; i++) begin
         rise_s       = thr_ok_s & ~s_next_s & (adc_bus[i*SAMPLE_W +: SAMPLE_W] >= lvl_hi);
         fall_s       = thr_ok_s &  s_next_s & (adc_bus[i*SAMPLE_W +: SAMPLE_W] <= lvl_lo);
         qual_s       = (rise_s & edge_mode[0]) | (fall_s & edge_mode[1]);
         event_lane_s = (qual_s & ~event_s) ? LW'(i) : event_lane_s;
         event_s      = event_s | qual_s;
         s_next_s     = s_next_s ^ (rise_s | fall_s);
      end
   end

   // Control-side decodes: input edges, event qualification and count completion.
   always_comb begin
      arm_rise_s   = arm & ~arm_q_r;
      force_rise_s = force_trig & ~force_q_r;
      qualify_s    = adc_valid & event_s;
      ev_next_s    = {1'b0, ev_r} + EV_ONE;
      ev_need_s    = (ev_count == {EVCNT_W{1'b0}}) ? EV_ONE : {1'b0, ev_count};
      ev_done_s    = (ev_next_s >= ev_need_s);
   end

   // Trigger FSM with registered outputs; disarm dominates everything except force.
   always_ff @(posedge adc_data_clk or negedge adc_rst_n) begin
      if (!adc_rst_n) begin
         state_r    <= IDLE;
         s_r        <= 1'b0;
         hold_cnt_r <= {HOLDOFF_W{1'b0}};
         arm_q_r    <= 1'b0;
         force_q_r  <= 1'b0;
         trig_r     <= 1'b0;
         sub_r      <= {LW{1'b0}};
         ev_r       <= {EVCNT_W{1'b0}};
      end else begin
         arm_q_r   <= arm;
         force_q_r <= force_trig;
         trig_r    <= 1'b0;
         if (adc_valid) begin
            s_r <= s_next_s;
         end
         if (force_rise_s) begin
            trig_r <= 1'b1;
            sub_r  <= {LW{1'b0}};
         end
         if (disarm) begin
            state_r <= IDLE;
            ev_r    <= {EVCNT_W{1'b0}};
         end else begin
            case (state_r)
               IDLE: begin
                  if (arm_rise_s) begin
                     state_r <= ARMED;
                     ev_r    <= {EVCNT_W{1'b0}};
                  end
               end
               ARMED: begin
                  if (force_rise_s) begin
                     state_r    <= HOLDOFF;
                     hold_cnt_r <= holdoff;
                     ev_r       <= {EVCNT_W{1'b0}};
                  end else if (qualify_s) begin
                     if (ev_done_s) begin
                        trig_r     <= 1'b1;
                        sub_r      <= event_lane_s;
                        ev_r       <= {EVCNT_W{1'b0}};
                        state_r    <= HOLDOFF;
                        hold_cnt_r <= holdoff;
                     end else begin
                        ev_r <= ev_next_s[EVCNT_W-1:0];
                     end
                  end
               end
               HOLDOFF: begin
                  if (hold_cnt_r == {HOLDOFF_W{1'b0}}) begin
                     state_r <= auto_rearm ? ARMED : IDLE;
                  end else begin
                     hold_cnt_r <= hold_cnt_r - HOLD_ONE;
                  end
               end
               default: begin
                  state_r <= IDLE;
                  ev_r    <= {EVCNT_W{1'b0}};
               end
            endcase
         end
      end
   end

   assign trigger_out      = trig_r;
   assign trigger_sub_word = sub_r;
   assign trig_state       = state_r;
   assign ev_counter       = ev_r;

endmodule

// File: tb/tb_adc_trigger_edge_multi.sv
// Scoreboard bench for adc_trigger_edge_multi: directed words push expected fires (lane, state,
// cycle) into a queue that a negedge monitor drains whenever trigger_out pulses.
module tb_adc_trigger_edge_multi;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] adc_bus;
   logic        adc_valid;
   logic [7:0]  lvl_hi, lvl_lo;
   logic [1:0]  edge_mode;
   logic [7:0]  ev_count;
   logic [15:0] holdoff;
   logic        auto_rearm, arm, disarm, force_trig;
   logic        trigger_out;
   logic [2:0]  trigger_sub_word;
   logic [1:0]  trig_state;
   logic [7:0]  ev_counter;

   typedef struct {
      logic [2:0] sub;
      logic [1:0] st;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   n0;

   localparam logic [1:0] S_IDLE = 2'b00, S_ARMED = 2'b01, S_HOLD = 2'b10;

   adc_trigger_edge_multi dut (
      .adc_data_clk     (clk),
      .adc_rst_n        (rst_n),
      .adc_bus          (adc_bus),
      .adc_valid        (adc_valid),
      .lvl_hi           (lvl_hi),
      .lvl_lo           (lvl_lo),
      .edge_mode        (edge_mode),
      .ev_count         (ev_count),
      .holdoff          (holdoff),
      .auto_rearm       (auto_rearm),
      .arm              (arm),
      .disarm           (disarm),
      .force_trig       (force_trig),
      .trigger_out      (trigger_out),
      .trigger_sub_word (trigger_sub_word),
      .trig_state       (trig_state),
      .ev_counter       (ev_counter)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every trigger pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (trigger_out === 1'b1) begin
         exp_t e;
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_fire: got trigger_out=1 sub=%0d at cycle %0d, want no fire",
                     trigger_sub_word, cyc);
         end else begin
            e = exp_q.pop_front();
            if (trigger_sub_word !== e.sub || trig_state !== e.st || cyc != e.cyc) begin
               n_fail++;
               $display("FAIL fire: got sub=%0d state=%0d cycle=%0d, want sub=%0d state=%0d cycle=%0d",
                        trigger_sub_word, trig_state, cyc, e.sub, e.st, e.cyc);
            end
         end
      end
   end

   function automatic logic [63:0] w8(input logic [7:0] a, b, c, d, e, f, g, h);
      return {h, g, f, e, d, c, b, a};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [63:0] w);
      adc_bus   = w;
      adc_valid = 1'b1;
      tick();
      adc_valid = 1'b0;
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic push(input logic [2:0] sub, input logic [1:0] st, input int at);
      exp_t e;
      e.sub = sub;
      e.st  = st;
      e.cyc = at;
      exp_q.push_back(e);
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, got, want);
      end
   endtask

   task automatic wait_idle();
      repeat (8) tick();
      check("back_to_idle", {30'd0, trig_state}, 32'd0);
   endtask

   logic [63:0] word_x, word_a;

   initial begin
      rst_n = 1'b0; adc_bus = 64'd0; adc_valid = 1'b0;
      lvl_hi = 8'h80; lvl_lo = 8'h70; edge_mode = 2'b01; ev_count = 8'd1;
      holdoff = 16'd5; auto_rearm = 1'b0; arm = 1'b0; disarm = 1'b0; force_trig = 1'b0;
      word_x = w8(8'h10, 8'h10, 8'h10, 8'h10, 8'h90, 8'h90, 8'h90, 8'h90);
      word_a = w8(8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h85);

      repeat (3) tick();
      check("rst_trigger_out", {31'd0, trigger_out}, 32'd0);
      check("rst_state", {30'd0, trig_state}, 32'd0);
      check("rst_ev_counter", {24'd0, ev_counter}, 32'd0);
      check("rst_sub_word", {29'd0, trigger_sub_word}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Basic rising edge at lane 3
      pulse_arm();
      check("armed", {30'd0, trig_state}, {30'd0, S_ARMED});
      send(w8(8'h10, 8'h10, 8'h10, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90));
      push(3'd3, S_HOLD, cyc);
      check("holdoff_entered", {30'd0, trig_state}, {30'd0, S_HOLD});
      wait_idle();
      check("sub_word_holds", {29'd0, trigger_sub_word}, 32'd3);

      // Falling with hysteresis: 0x78 stays above lvl_lo, 0x60 at lane 2 falls
      edge_mode = 2'b10;
      send(word_a);
      pulse_arm();
      send(w8(8'h78, 8'h78, 8'h60, 8'h60, 8'h60, 8'h60, 8'h60, 8'h60));
      push(3'd2, S_HOLD, cyc);
      wait_idle();

      // Rising only on word A: lane 7
      edge_mode = 2'b01;
      pulse_arm();
      send(word_a);
      push(3'd7, S_HOLD, cyc);
      wait_idle();

      // Exact thresholds: 0x70 falls at lane 0, 0x80 rises at lane 1
      pulse_arm();
      send(w8(8'h70, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80));
      push(3'd1, S_HOLD, cyc);
      wait_idle();

      // Event count of 3
      ev_count = 8'd3;
      pulse_arm();
      send(word_x);
      check("ev_counter_1", {24'd0, ev_counter}, 32'd1);
      send(word_x);
      check("ev_counter_2", {24'd0, ev_counter}, 32'd2);
      send(word_x);
      push(3'd4, S_HOLD, cyc);
      check("ev_counter_cleared", {24'd0, ev_counter}, 32'd0);
      wait_idle();

      // Noise inside the hysteresis band, inverted thresholds, and mode none
      ev_count = 8'd1;
      pulse_arm();
      repeat (4) send(w8(8'h72, 8'h7e, 8'h72, 8'h7e, 8'h72, 8'h7e, 8'h72, 8'h7e));
      lvl_lo = 8'h90;
      send(word_x);
      lvl_lo = 8'h70;
      edge_mode = 2'b00;
      send(word_x);
      edge_mode = 2'b01;
      check("noise_still_armed", {30'd0, trig_state}, {30'd0, S_ARMED});
      check("noise_ev_counter", {24'd0, ev_counter}, 32'd0);

      // Holdoff 5 with auto re-arm: fires 7 clocks apart
      auto_rearm = 1'b1;
      send(word_x);
      n0 = cyc;
      push(3'd4, S_HOLD, n0);
      push(3'd4, S_HOLD, n0 + 7);
      push(3'd4, S_HOLD, n0 + 14);
      repeat (15) send(word_x);
      disarm = 1'b1;
      tick();
      disarm = 1'b0;
      check("disarm_idle", {30'd0, trig_state}, {30'd0, S_IDLE});
      repeat (10) send(word_x);
      check("disarm_stays_idle", {30'd0, trig_state}, {30'd0, S_IDLE});
      auto_rearm = 1'b0;

      // Force in IDLE, then force in ARMED beating a simultaneous event
      force_trig = 1'b1;
      tick();
      push(3'd0, S_IDLE, cyc);
      force_trig = 1'b0;
      check("force_idle_state", {30'd0, trig_state}, {30'd0, S_IDLE});
      pulse_arm();
      force_trig = 1'b1;
      send(word_x);
      push(3'd0, S_HOLD, cyc);
      force_trig = 1'b0;
      check("force_armed_state", {30'd0, trig_state}, {30'd0, S_HOLD});
      wait_idle();

      // Asynchronous reset mid-HOLDOFF
      pulse_arm();
      send(word_x);
      push(3'd4, S_HOLD, cyc);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("async_rst_state", {30'd0, trig_state}, 32'd0);
      check("async_rst_sub", {29'd0, trigger_sub_word}, 32'd0);
      check("async_rst_trigger", {31'd0, trigger_out}, 32'd0);
      check("async_rst_ev", {24'd0, ev_counter}, 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (6) send(word_x);
      check("post_rst_idle", {30'd0, trig_state}, {30'd0, S_IDLE});

      repeat (2) tick();
      check("queue_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/adc_trigger_edge_multi.md
# adc_trigger_edge_multi

Parametrised multi-lane hysteresis edge trigger, successor to the fixed 8×8-bit ADC edge trigger. It takes one packed word of LANES samples per clock from a single ADC channel and runs a hysteresis comparator across the lanes in sample order. It qualifies edges by polarity and requires N qualifying events before firing. It then applies a holdoff period and re-arms once or continuously. It sits between the ADC deserialiser and the acquisition controller, which consumes `trigger_out`/`trigger_sub_word`.

## Interface
- `LANES`, 8: samples per word; power of two, ≥2; lane 0 is the oldest sample.
- `SAMPLE_W`, 8: bits per sample, unsigned.
- `HOLDOFF_W`, 16: holdoff counter width.
- `EVCNT_W`, 8: event-count width.

Ports:
- `adc_data_clk`  in  1  sample clock; all logic on rising edge.
- `adc_rst_n`  in  1  asynchronous, active-low reset.
- `adc_bus`  in  LANES*SAMPLE_W  packed samples; lane i = bits [i*SAMPLE_W +: SAMPLE_W].
- `adc_valid`  in  1  word valid this cycle.
- `lvl_hi`, `lvl_lo`  in  SAMPLE_W  upper/lower hysteresis thresholds.
- `edge_mode`  in  2  00 none, 01 rising, 10 falling, 11 either.
- `ev_count`  in  EVCNT_W  qualifying events per trigger; 0 treated as 1.
- `holdoff`  in  HOLDOFF_W  holdoff length in clocks.
- `auto_rearm`  in  1  1: HOLDOFF→ARMED; 0: HOLDOFF→IDLE.
- `arm`  in  1  rising edge arms from IDLE.
- `disarm`  in  1  level; forces IDLE.
- `force`  in  1  rising edge forces a trigger.
- `trigger_out`  out  1  single-cycle trigger pulse.
- `trigger_sub_word`  out  $clog2(LANES)  lane index of the triggering sample.
- `trig_state`  out  2  00 IDLE, 01 ARMED, 10 HOLDOFF.
- `ev_counter`  out  EVCNT_W  current event count.

## Operation
- Comparator state bit `s` is updated only when `adc_valid`=1, in all FSM states, and chains through lanes 0..LANES-1 in one cycle.
- Per lane: if `s`=0 and sample ≥ `lvl_hi`, then `s`←1 and a rising event occurs at that lane. If `s`=1 and sample ≤ `lvl_lo`, then `s`←0 and a falling event occurs.
- The final `s` carries to the next word, so an edge spanning a word boundary is detected in the later word.
- Several events may occur in one word. Only the lowest-index qualifying event counts: at most 1 per word.
- If `lvl_lo` ≥ `lvl_hi`, no events are generated and `s` holds.
- FSM states:
  - IDLE: `arm` rising edge → ARMED and `ev_counter`←0.
  - ARMED: on a qualifying word, if `ev_counter`+1 ≥ max(`ev_count`,1), fire, set `ev_counter`←0 and go to HOLDOFF. Otherwise `ev_counter`+1.
  - HOLDOFF: counter loaded with `holdoff` on entry and decremented every clock. When it reaches 0, go to ARMED (`auto_rearm`=1) or IDLE. With `holdoff`=0, HOLDOFF lasts exactly 1 clock.
- Events in IDLE and HOLDOFF are ignored and not counted.
- `disarm`=1 forces IDLE and clears `ev_counter` from any state. It overrides `arm` and events in the same cycle, but not `force`.
- `force` rising edge fires with `trigger_sub_word`=0 in any state.
  - In ARMED it also enters HOLDOFF and clears `ev_counter`.
  - In IDLE or HOLDOFF the state is unchanged.
  - A simultaneous real event is discarded in favour of `force`.
- `edge_mode`=00 never fires except by `force`.

## Timing
- Reset values: `trigger_out`=0, `trigger_sub_word`=0, `trig_state`=IDLE, `ev_counter`=0, `s`=0, holdoff counter=0, arm/force edge registers=0.
- Latency: a word sampled at edge k with `adc_valid`=1 produces `trigger_out`=1 during cycle k+1, for exactly 1 cycle. `trigger_sub_word` is valid in the same cycle and holds until the next fire.
- `arm`/`force` edge detection is registered; the action takes effect 1 clock after the input rises.
- Thresholds and mode are sampled every cycle; changing them mid-operation takes effect on the next word.
- Consecutive fires are at least `holdoff`+2 clocks apart, except for `force` outside ARMED.
- Reset asserted mid-HOLDOFF or while ARMED returns everything to reset values asynchronously. No pulse is emitted on deassertion.

## Test plan
- Rising edge: LANES=8, `lvl_hi`=0x80, `lvl_lo`=0x70, `edge_mode`=01, `ev_count`=1, armed. Word lanes 0..7 = 0x10,0x10,0x10,0x90,… → `trigger_out` 1 cycle later, `trigger_sub_word`=3, `trig_state`=HOLDOFF.
- Hysteresis and boundary: word A lanes = 0x10…0x10,0x85. Word B = 0x78 (no falling, above `lvl_lo`), then 0x60 at lane 2, with `edge_mode`=10 → single fire after B, `trigger_sub_word`=2. Rising only: fire after A, `trigger_sub_word`=7.
- Event count: `ev_count`=3, a rising edge every word → `ev_counter` 1,2 then fire on the 3rd word. Noise with amplitude < `lvl_hi`−`lvl_lo` → no fire.
- Holdoff: `holdoff`=5, `auto_rearm`=1, continuous edges → fires 7 clocks apart. `auto_rearm`=0 → one fire, then `trig_state`=IDLE.
- Force/disarm: `force` pulse in IDLE → `trigger_out`=1, `trigger_sub_word`=0, state stays IDLE. `disarm` during HOLDOFF → IDLE next clock, no further fires.
- Reset mid-HOLDOFF: assert `adc_rst_n`=0 asynchronously → all outputs 0 and IDLE immediately. Deassert → no pulse until re-armed.
